leaf_out_arbiter: RTL and testbench
===================================

Name: leaf_out_arbiter

Overview:
- Sequences a leaf's user output streams onto the single BFT-bound packet link.
- Round-robin arbitrates among NUM_OUT_PORTS valid/ack user streams of 32-bit payload.
- Per port: stamps the configured destination (leaf, port) and a running BRAM write address, and enforces per-port freespace credit.
- Sits between the user kernel outputs and the dout_leaf_interface2bft path inside the leaf interface.

Parameters:
- PACKET_BITS, 49, packet width: {vld, leaf, port, addr, payload}
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, address field width; must equal NUM_BRAM_ADDR_BITS
- NUM_OUT_PORTS, 3, number of user output streams (1..15)
- NUM_BRAM_ADDR_BITS, 7, receiver BRAM depth = 2^7 = 128 words
- FREESPACE_UPDATE_SIZE, 64, credits returned per freespace update

Ports:
- clk, in, 1, single clock
- reset_n, in, 1, asynchronous active-low reset
- din_user, in, NUM_OUT_PORTS*PAYLOAD_BITS, user payloads; port i at slice i
- vld_user, in, NUM_OUT_PORTS, user valid per port
- ack_user, out, NUM_OUT_PORTS, accept strobe per port
- cfg_we, in, 1, destination table write
- cfg_idx, in, NUM_PORT_BITS, output port index being configured
- cfg_leaf, in, NUM_LEAF_BITS, destination leaf
- cfg_port, in, NUM_PORT_BITS, destination port
- cfg_en, in, 1, enable bit for port cfg_idx
- upd_vld, in, 1, freespace update strobe
- upd_idx, in, NUM_PORT_BITS, port receiving the credit update
- pkt_out, out, PACKET_BITS, packet to BFT; bit 48 is the valid bit
- pkt_rdy, in, 1, BFT accepts pkt_out this cycle
- resend, in, 1, freeze: no new grants
- credit_ovf, out, 1, sticky credit overflow error

Behaviour:
- Reset (async assert, sync release):
  - pkt_out=0, ack_user=0, credit_ovf=0.
  - All cfg entries disabled (leaf=0, port=0).
  - Credits = 2^NUM_BRAM_ADDR_BITS (128); counters are NUM_BRAM_ADDR_BITS+1 bits.
  - Address counters = 0; round-robin pointer = 0.
- Output register FSM, states EMPTY and FULL:
  - EMPTY -> FULL on a grant.
  - FULL & pkt_rdy & grant -> FULL (back-to-back, one packet per cycle).
  - FULL & pkt_rdy & no grant -> EMPTY; pkt_out valid bit cleared.
  - FULL & !pkt_rdy -> FULL; pkt_out held stable.
- Grant conditions:
  - The output register can load: EMPTY, or FULL & pkt_rdy.
  - resend=0.
  - Port i is eligible when vld_user[i] & cfg_en[i] & credit[i] != 0.
  - Winner: first eligible port at or after the RR pointer, wrapping modulo NUM_OUT_PORTS. Pointer becomes winner+1 (wraps).
- Grant actions:
  - ack_user[winner]=1, combinational in the grant cycle; all other acks 0. The user drops or advances data on ack.
  - Next edge: pkt_out = {1, leaf[w], port[w], addr[w], din[w]}.
  - addr[w]++ (wraps 127->0); credit[w]--.
  - Latency: vld sampled at cycle t -> pkt_out valid at t+1.
- Credit updates:
  - upd_vld adds FREESPACE_UPDATE_SIZE to credit[upd_idx].
  - Simultaneous grant and update on the same port: net +63.
  - Result > 128: saturate at 128 and set credit_ovf (sticky until reset).
  - upd_idx >= NUM_OUT_PORTS: ignored.
- Configuration:
  - cfg_we writes the entry at the edge; the new destination applies to grants from the next cycle.
  - A packet already in pkt_out keeps its old header.
  - Disabling a port with vld high: the port is never acked.
  - Out-of-range cfg_idx: ignored.
- resend=1:
  - No grants and no acks.
  - A FULL register still completes on pkt_rdy, then goes EMPTY; credits and addresses unchanged.
- Reset mid-transfer: the packet in pkt_out is discarded; all state returns to reset values.

Decomposition:
- Shared package leaf_pkg:
  - packet field offsets/widths (VLD_BIT=48, LEAF_LSB=43, PORT_LSB=39, ADDR_LSB=32);
  - credit counter width;
  - typedef of a cfg entry {en, leaf, port}.
- Sub-module rr_arbiter: NUM_OUT_PORTS-wide request -> one-hot grant, with pointer state and an advance input.
- The top level holds the output FSM, credit counters, address counters and cfg table.

Test Plan:
- Single port, ordered payloads:
  - Stimulus: port0 cfg leaf=5, port=2, en=1; vld_user[0]=1 with payloads 0xA0..0xA3; pkt_rdy=1.
  - Required: 4 consecutive packets, header leaf=5 port=2, addr 0,1,2,3, payloads in order; ack pulses aligned one cycle before each packet.
- Fairness:
  - Stimulus: all 3 ports enabled and continuously valid, pkt_rdy=1.
  - Required: grant order 0,1,2,0,1,2; each port gets exactly 4 packets in 12 cycles.
- Backpressure:
  - Stimulus: pkt_rdy=0 for 5 cycles while port1 is valid.
  - Required: pkt_out stable; exactly one ack issued; second ack only in the cycle pkt_rdy returns.
- Credit exhaustion and refill:
  - Stimulus: send 128 words on port2 with no update; then one upd_vld for port2.
  - Required: 129th word not acked; the update restores exactly 64 sends; addr wraps 127->0.
- Overflow and simultaneous events:
  - Stimulus: upd_vld on a full-credit port.
  - Required: credit stays 128 and credit_ovf=1.
  - Stimulus: grant and update on the same port in the same cycle.
  - Required: net credit change +63.
- resend and reset:
  - Stimulus: assert resend with pkt_out FULL, pkt_rdy=1.
  - Required: pkt_out drains and no new acks.
  - Stimulus: reset_n low mid-stream.
  - Required: pkt_out=0 immediately (async); credits 128, addresses 0 after release.

Source files
------------

// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf output arbiter: packet field layout,
// credit counter width, configuration entry and output register states.
package leaf_pkg;

   // Packet layout {vld, leaf, port, addr, payload}
   localparam int VLD_BIT     = 48;
   localparam int LEAF_LSB    = 43;
   localparam int PORT_LSB    = 39;
   localparam int ADDR_LSB    = 32;

   localparam int LEAF_W      = 5;
   localparam int PORT_W      = 4;
   localparam int BRAM_ADDR_W = 7;

   // One extra bit so a full receiver BRAM (2^BRAM_ADDR_W credits) is representable
   localparam int CREDIT_W    = BRAM_ADDR_W + 1;

   typedef struct packed {
      logic              en;
      logic [LEAF_W-1:0] leaf;
      logic [PORT_W-1:0] port;
   } cfg_entry_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// User stream and BFT-side packet handshake bundle for the leaf output arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface leaf_out_arbiter_if #(
   parameter int NUM_OUT_PORTS = 3,
   parameter int PAYLOAD_BITS  = 32,
   parameter int PACKET_BITS   = 49
);
   logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
   logic [NUM_OUT_PORTS-1:0]              vld_user;
   logic [NUM_OUT_PORTS-1:0]              ack_user;
   logic [PACKET_BITS-1:0]                pkt_out;
   logic                                  pkt_rdy;
   logic                                  resend;

   modport master (
      input  din_user,
      input  vld_user,
      input  pkt_rdy,
      input  resend,
      output ack_user,
      output pkt_out
   );

   modport slave (
      output din_user,
      output vld_user,
      output pkt_rdy,
      output resend,
      input  ack_user,
      input  pkt_out
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer, wrapping. The pointer moves past the winner only when advance is set.
module rr_arbiter #(
   parameter int NUM_REQ = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] gnt
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   ptr_d;
   logic [PTR_W-1:0]   win;
   logic [NUM_REQ-1:0] masked;
   logic [NUM_REQ-1:0] sel;

   // Prefer requests at or above the pointer; fall back to all requests to wrap.
   always_comb begin
      masked = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         masked[i] = req[i] && (i >= int'(ptr_q));
      end
      sel = (|masked) ? masked : req;
      win = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (sel[i]) win = PTR_W'(i);
      end
      gnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt[i] = sel[i] && (win == PTR_W'(i));
      end
      ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
   end

   // Pointer moves one past the winner whenever a grant is taken.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else if (advance) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Leaf output arbiter: round-robins the user output streams onto the single
// BFT packet link, stamping each word with its configured destination and a
// running receiver BRAM address, and gating each stream on freespace credit.
module leaf_out_arbiter
   import leaf_pkg::*;
#(
   parameter int PACKET_BITS           = 49,
   parameter int PAYLOAD_BITS          = 32,
   parameter int NUM_LEAF_BITS         = 5,
   parameter int NUM_PORT_BITS         = 4,
   parameter int NUM_ADDR_BITS         = 7,
   parameter int NUM_OUT_PORTS         = 3,
   parameter int NUM_BRAM_ADDR_BITS    = 7,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                     clk,
   input  logic                     reset_n,
   leaf_out_arbiter_if.master       bus,
   input  logic                     cfg_we,
   input  logic [NUM_PORT_BITS-1:0] cfg_idx,
   input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
   input  logic [NUM_PORT_BITS-1:0] cfg_port,
   input  logic                     cfg_en,
   input  logic                     upd_vld,
   input  logic [NUM_PORT_BITS-1:0] upd_idx,
   output logic                     credit_ovf
);
   localparam int                SUM_W      = CREDIT_W + 1;
   localparam logic [SUM_W-1:0]  CREDIT_MAX = SUM_W'(1) << NUM_BRAM_ADDR_BITS;
   localparam logic [SUM_W-1:0]  UPD_AMT    = SUM_W'(FREESPACE_UPDATE_SIZE);

   cfg_entry_t               cfg_q    [NUM_OUT_PORTS];
   logic [CREDIT_W-1:0]      credit_q [NUM_OUT_PORTS];
   logic [CREDIT_W-1:0]      credit_d [NUM_OUT_PORTS];
   logic [SUM_W-1:0]         sum_c    [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];

   logic [NUM_OUT_PORTS-1:0] eligible;
   logic [NUM_OUT_PORTS-1:0] req;
   logic [NUM_OUT_PORTS-1:0] gnt;
   logic [NUM_OUT_PORTS-1:0] upd_hit;
   logic                     grant;
   logic                     can_load;
   logic                     ovf_set;

   out_state_t               state_q;
   out_state_t               state_d;
   logic [PACKET_BITS-1:0]   pkt_p0;
   logic [PACKET_BITS-1:0]   pkt_p1;

   // Per-port eligibility and request gating on register space and resend.
   always_comb begin
      eligible = '0;
      upd_hit  = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         eligible[i] = bus.vld_user[i] && cfg_q[i].en && (credit_q[i] != '0);
         upd_hit[i]  = upd_vld && (upd_idx == NUM_PORT_BITS'(i));
      end
      req = (can_load && !bus.resend) ? eligible : '0;
   end

   rr_arbiter #(
      .NUM_REQ (NUM_OUT_PORTS)
   ) u_rr_arbiter (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .advance (grant),
      .gnt     (gnt)
   );

   assign grant        = |gnt;
   assign bus.ack_user = gnt;
   assign bus.pkt_out  = pkt_p1;

   // Output register state: next state plus the load-enable it implies.
   always_comb begin
      state_d  = state_q;
      can_load = (state_q == EMPTY) || bus.pkt_rdy;
      case (state_q)
         EMPTY:   if (grant) state_d = FULL;
         FULL:    if (bus.pkt_rdy && !grant) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Output register state update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- stage p0: assemble the winner's packet from its table entry and counters
   always_comb begin
      pkt_p0          = '0;
      pkt_p0[VLD_BIT] = 1'b1;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         if (gnt[i]) begin
            pkt_p0[LEAF_LSB +: NUM_LEAF_BITS] = cfg_q[i].leaf;
            pkt_p0[PORT_LSB +: NUM_PORT_BITS] = cfg_q[i].port;
            pkt_p0[ADDR_LSB +: NUM_ADDR_BITS] = addr_q[i];
            pkt_p0[0 +: PAYLOAD_BITS]         = bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
         end
      end
   end

   // ---- stage p1: packet register; held under backpressure, cleared once drained
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_p1 <= '0;
      end else if (grant) begin
         pkt_p1 <= pkt_p0;
      end else if ((state_q == FULL) && bus.pkt_rdy) begin
         pkt_p1 <= '0;
      end
   end

   // Next credit per port: +update, -grant, saturating at a full BRAM.
   always_comb begin
      ovf_set = 1'b0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         sum_c[i] = {1'b0, credit_q[i]}
                  + (upd_hit[i] ? UPD_AMT : '0)
                  - (gnt[i] ? SUM_W'(1) : '0);
         if (sum_c[i] > CREDIT_MAX) begin
            credit_d[i] = CREDIT_W'(CREDIT_MAX);
            ovf_set     = 1'b1;
         end else begin
            credit_d[i] = sum_c[i][CREDIT_W-1:0];
         end
      end
   end

   // Credit and write-address counters; addresses wrap with the BRAM depth.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= CREDIT_W'(CREDIT_MAX);
            addr_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= credit_d[i];
            if (gnt[i]) addr_q[i] <= addr_q[i] + NUM_ADDR_BITS'(1);
         end
      end
   end

   // Sticky overflow flag: only reset clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         credit_ovf <= 1'b0;
      end else if (ovf_set) begin
         credit_ovf <= 1'b1;
      end
   end

   // Destination table; writes to indices beyond the last port fall through.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            cfg_q[i] <= '0;
         end
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (cfg_idx == NUM_PORT_BITS'(i)) begin
               cfg_q[i] <= '{en: cfg_en, leaf: cfg_leaf, port: cfg_port};
            end
         end
      end
   end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Self-checking bench for leaf_out_arbiter: a vector table for ordered and
// fair streaming, plus hand sequences for backpressure, credits, resend, reset.
module tb_leaf_out_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cfg_we;
   logic [3:0] cfg_idx;
   logic [4:0] cfg_leaf;
   logic [3:0] cfg_port;
   logic       cfg_en;
   logic       upd_vld;
   logic [3:0] upd_idx;
   logic       credit_ovf;

   always #5 clk = ~clk;

   leaf_out_arbiter_if #(
      .NUM_OUT_PORTS (3),
      .PAYLOAD_BITS  (32),
      .PACKET_BITS   (49)
   ) bus ();

   leaf_out_arbiter dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_leaf   (cfg_leaf),
      .cfg_port   (cfg_port),
      .cfg_en     (cfg_en),
      .upd_vld    (upd_vld),
      .upd_idx    (upd_idx),
      .credit_ovf (credit_ovf)
   );

   typedef struct {
      bit          rst;
      logic [2:0]  vld;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [2:0]  ack;
      logic [48:0] pkt;
   } vec_t;

   localparam int NV = 18;
   vec_t vt [NV];

   logic [4:0] lf [3];
   logic [3:0] pt [3];
   int         n_chk = 0;
   int         n_pass = 0;
   int         cnt;
   int         fair_cnt [3];
   logic [2:0] a;
   logic [48:0] held;

   function automatic logic [48:0] mkpkt(input logic [4:0] l, input logic [3:0] p,
                                         input logic [6:0] ad, input logic [31:0] d);
      return {1'b1, l, p, ad, d};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic setd(input int p, input logic [31:0] d);
      bus.din_user[p*32 +: 32] = d;
   endtask

   // One clock: sample the combinational ack, then move to just after the edge.
   task automatic cyc(output logic [2:0] ack);
      #1;
      ack = bus.ack_user;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [3:0] idx, input logic [4:0] l,
                            input logic [3:0] p, input logic en);
      cfg_we = 1'b1; cfg_idx = idx; cfg_leaf = l; cfg_port = p; cfg_en = en;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   task automatic do_reset();
      bus.vld_user = '0; bus.din_user = '0; bus.pkt_rdy = 1'b1; bus.resend = 1'b0;
      cfg_we = 1'b0; cfg_idx = '0; cfg_leaf = '0; cfg_port = '0; cfg_en = 1'b0;
      upd_vld = 1'b0; upd_idx = '0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      cfg_write(4'd0, 5'd5, 4'd2, 1'b1);
      cfg_write(4'd1, 5'd6, 4'd3, 1'b1);
      cfg_write(4'd2, 5'd7, 4'd1, 1'b1);
   endtask

   initial begin
      lf[0] = 5'd5; lf[1] = 5'd6; lf[2] = 5'd7;
      pt[0] = 4'd2; pt[1] = 4'd3; pt[2] = 4'd1;

      // Single port, ordered payloads A0..A3, then idle drains the register
      for (int k = 0; k < 4; k++) begin
         vt[k] = '{rst: (k == 0), vld: 3'b001, d0: 32'hA0 + k, d1: 0, d2: 0,
                   ack: 3'b001, pkt: mkpkt(5'd5, 4'd2, 7'(k), 32'hA0 + k)};
      end
      vt[4] = '{rst: 0, vld: 3'b000, d0: 0, d1: 0, d2: 0, ack: 3'b000, pkt: '0};
      // Fairness: all three ports streaming, rotation 0,1,2
      for (int k = 0; k < 12; k++) begin
         vt[5+k] = '{rst: (k == 0), vld: 3'b111, d0: 32'hB0, d1: 32'hB1, d2: 32'hB2,
                     ack: 3'(1 << (k % 3)),
                     pkt: mkpkt(lf[k%3], pt[k%3], 7'(k / 3), 32'hB0 + (k % 3))};
      end
      vt[17] = '{rst: 0, vld: 3'b000, d0: 0, d1: 0, d2: 0, ack: 3'b000, pkt: '0};

      // Reset state
      bus.vld_user = '0; bus.din_user = '0; bus.pkt_rdy = 1'b1; bus.resend = 1'b0;
      cfg_we = 1'b0; cfg_idx = '0; cfg_leaf = '0; cfg_port = '0; cfg_en = 1'b0;
      upd_vld = 1'b0; upd_idx = '0;
      reset_n = 1'b0;
      #3;
      chk("reset_pkt", bus.pkt_out, 49'd0);
      chk("reset_ack", bus.ack_user, 3'd0);
      chk("reset_ovf", credit_ovf, 1'b0);

      // Vector table
      for (int p = 0; p < 3; p++) fair_cnt[p] = 0;
      for (int r = 0; r < NV; r++) begin
         if (vt[r].rst) do_reset();
         bus.vld_user = vt[r].vld;
         setd(0, vt[r].d0); setd(1, vt[r].d1); setd(2, vt[r].d2);
         bus.pkt_rdy = 1'b1;
         #1;
         chk($sformatf("vec%0d_ack", r), bus.ack_user, vt[r].ack);
         if (r >= 5 && r < 17) begin
            for (int p = 0; p < 3; p++) if (bus.ack_user[p]) fair_cnt[p]++;
         end
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_pkt", r), bus.pkt_out, vt[r].pkt);
      end
      for (int p = 0; p < 3; p++) chk($sformatf("fair_cnt%0d", p), fair_cnt[p], 4);

      // Backpressure on port1, with a destination change while the packet is held
      do_reset();
      bus.vld_user = 3'b010; setd(1, 32'hC0); bus.pkt_rdy = 1'b0;
      cyc(a);
      chk("bp_first_ack", a, 3'b010);
      held = mkpkt(5'd6, 4'd3, 7'd0, 32'hC0);
      chk("bp_first_pkt", bus.pkt_out, held);
      setd(1, 32'hC1);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            cfg_we = 1'b1; cfg_idx = 4'd1; cfg_leaf = 5'd9; cfg_port = 4'd4; cfg_en = 1'b1;
         end
         cyc(a);
         cfg_we = 1'b0;
         if (a != 3'b000) cnt++;
         chk($sformatf("bp_hold%0d", i), bus.pkt_out, held);
      end
      chk("bp_no_extra_ack", cnt, 0);
      bus.pkt_rdy = 1'b1;
      cyc(a);
      chk("bp_second_ack", a, 3'b010);
      chk("bp_second_pkt", bus.pkt_out, mkpkt(5'd9, 4'd4, 7'd1, 32'hC1));

      // Credit exhaustion on port2, out-of-range update, then refill
      do_reset();
      bus.vld_user = 3'b100;
      cnt = 0;
      for (int i = 0; i < 128; i++) begin
         setd(2, i);
         cyc(a);
         if (a == 3'b100) cnt++;
         if (i == 127) chk("ce_pkt127", bus.pkt_out, mkpkt(5'd7, 4'd1, 7'd127, 32'd127));
      end
      chk("ce_sent_128", cnt, 128);
      cyc(a);
      chk("ce_129_not_acked", a, 3'b000);
      chk("ce_drained", bus.pkt_out, 49'd0);
      bus.vld_user = 3'b000; upd_vld = 1'b1; upd_idx = 4'd3;
      cyc(a);
      upd_vld = 1'b0; bus.vld_user = 3'b100;
      cyc(a);
      chk("ce_bad_idx_ignored", a, 3'b000);
      bus.vld_user = 3'b000; upd_vld = 1'b1; upd_idx = 4'd2;
      cyc(a);
      upd_vld = 1'b0; bus.vld_user = 3'b100; setd(2, 32'h200);
      cyc(a);
      chk("ce_refill_ack", a, 3'b100);
      chk("ce_addr_wrap", bus.pkt_out, mkpkt(5'd7, 4'd1, 7'd0, 32'h200));
      cnt = 1;
      for (int i = 0; i < 70; i++) begin
         cyc(a);
         if (a == 3'b100) cnt++;
      end
      chk("ce_refill_64", cnt, 64);
      chk("ce_no_ovf", credit_ovf, 1'b0);

      // Update on a full-credit port saturates and flags overflow
      do_reset();
      upd_vld = 1'b1; upd_idx = 4'd0;
      cyc(a);
      upd_vld = 1'b0;
      chk("ovf_set", credit_ovf, 1'b1);
      bus.vld_user = 3'b001;
      cnt = 0;
      for (int i = 0; i < 132; i++) begin
         cyc(a);
         if (a == 3'b001) cnt++;
      end
      chk("ovf_credit_128", cnt, 128);
      chk("ovf_sticky", credit_ovf, 1'b1);

      // Grant and update on the same port in one cycle
      do_reset();
      bus.vld_user = 3'b010;
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         cyc(a);
         if (a == 3'b010) cnt++;
      end
      chk("sim_pre_64", cnt, 64);
      upd_vld = 1'b1; upd_idx = 4'd1;
      cyc(a);
      upd_vld = 1'b0;
      chk("sim_grant_with_upd", a, 3'b010);
      cnt = 0;
      for (int i = 0; i < 132; i++) begin
         cyc(a);
         if (a == 3'b010) cnt++;
      end
      chk("sim_net_plus63", cnt, 127);
      chk("sim_no_ovf", credit_ovf, 1'b0);

      // resend drains a full register without new grants
      do_reset();
      bus.vld_user = 3'b001; setd(0, 32'hD0); bus.pkt_rdy = 1'b0;
      cyc(a);
      chk("rs_first_ack", a, 3'b001);
      chk("rs_first_pkt", bus.pkt_out, mkpkt(5'd5, 4'd2, 7'd0, 32'hD0));
      bus.resend = 1'b1; bus.pkt_rdy = 1'b1; setd(0, 32'hD1);
      cyc(a);
      chk("rs_no_ack0", a, 3'b000);
      chk("rs_drained", bus.pkt_out, 49'd0);
      cyc(a);
      chk("rs_no_ack1", a, 3'b000);
      bus.resend = 1'b0;
      cyc(a);
      chk("rs_resume_ack", a, 3'b001);
      chk("rs_resume_pkt", bus.pkt_out, mkpkt(5'd5, 4'd2, 7'd1, 32'hD1));

      // Asynchronous reset mid-stream
      bus.vld_user = 3'b111; setd(0, 32'hE0); setd(1, 32'hE1); setd(2, 32'hE2);
      repeat (4) cyc(a);
      chk("rst_mid_busy", bus.pkt_out[48], 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_async_pkt", bus.pkt_out, 49'd0);
      chk("rst_async_ack", bus.ack_user, 3'd0);
      do_reset();
      bus.vld_user = 3'b010; setd(1, 32'hE1);
      cyc(a);
      chk("rst_after_ack", a, 3'b010);
      chk("rst_after_addr0", bus.pkt_out, mkpkt(5'd6, 4'd3, 7'd0, 32'hE1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
